// File: rtl/qea_state_reader_if.sv
// qea_state_reader_if: state RAM read port plus probability stream; master = reader, slave = RAM/collector side.
interface qea_state_reader_if #(
  parameter int PE_NUM_WIDTH = 2,
  parameter int PE_NUM = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STATE_ADDR_WIDTH = 16
);
  logic [PE_NUM-1:0] o_state_ena;
  logic [PE_NUM-1:0] o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0] o_state_addra;
  logic [PE_NUM*2*DATA_WIDTH-1:0] i_state_dout;
  logic o_prob_valid;
  logic i_prob_ready;
  logic [DATA_WIDTH-1:0] o_prob_data;
  logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_prob_index;
  logic o_prob_last;
  modport master (
    output o_state_ena, o_state_wea, o_state_addra, o_prob_valid, o_prob_data, o_prob_index, o_prob_last,
    input i_state_dout, i_prob_ready
  );
  modport slave (
    input o_state_ena, o_state_wea, o_state_addra, o_prob_valid, o_prob_data, o_prob_index, o_prob_last,
    output i_state_dout, i_prob_ready
  );
endinterface

// File: rtl/qea_state_reader.sv
// qea_state_reader: sweeps QEA state RAM and streams |a|^2 per basis index.
// Define QEA_READER_NORM_EN to add the running probability sum and normalisation error flag.
module qea_state_reader #(
  parameter int PE_NUM_WIDTH = 2,
  parameter int PE_NUM = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FRAC_BIT = 30,
  parameter int MAX_QBIT_WIDTH = 6,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 1
`ifdef QEA_READER_NORM_EN
  , parameter int NORM_TOL = 256
`endif
) (
  input logic clk,
  input logic rst,
  input logic i_start,
  input logic [MAX_QBIT_WIDTH-1:0] i_qbit_num,
  qea_state_reader_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic [DATA_WIDTH+STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_norm_sum,
  output logic o_norm_err
);
  localparam int IW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int SW = DATA_WIDTH + IW;
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [STATE_ADDR_WIDTH-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
  logic [PE_NUM_WIDTH-1:0] lane_q, lane_d;
  logic [2:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pbuf_q [PE_NUM];
  logic [DATA_WIDTH-1:0] pbuf_d [PE_NUM];
  logic [MAX_QBIT_WIDTH-1:0] n_clamp;
  logic [STATE_ADDR_WIDTH:0] w_full;
  logic start, hs, at_last;
  function automatic logic [DATA_WIDTH-1:0] prob(input logic [2*DATA_WIDTH-1:0] slot);
    logic signed [2*DATA_WIDTH-1:0] re, im;
    logic [2*DATA_WIDTH:0] p;
    re = {{DATA_WIDTH{slot[2*DATA_WIDTH-1]}}, slot[2*DATA_WIDTH-1 -: DATA_WIDTH]};
    im = {{DATA_WIDTH{slot[DATA_WIDTH-1]}}, slot[DATA_WIDTH-1:0]};
    p = ({1'b0, re * re} + {1'b0, im * im}) >> NUM_FRAC_BIT;
    return |p[2*DATA_WIDTH:DATA_WIDTH] ? '1 : p[DATA_WIDTH-1:0];
  endfunction
  assign start = state_q == IDLE && i_start;
  assign hs = bus.o_prob_valid && bus.i_prob_ready;
  assign at_last = addr_q == last_addr_q;
  assign n_clamp = i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH) ? MAX_QBIT_WIDTH'(PE_NUM_WIDTH)
                 : i_qbit_num > MAX_QBIT_WIDTH'(IW) ? MAX_QBIT_WIDTH'(IW) : i_qbit_num;
  assign w_full = (STATE_ADDR_WIDTH+1)'(1) << (n_clamp - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    last_addr_d = last_addr_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    pbuf_d = pbuf_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = READ;
        addr_d = '0;
        lane_d = '0;
        last_addr_d = STATE_ADDR_WIDTH'(w_full - 1'b1);
      end
      READ: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (cnt_q == 3'(RD_LATENCY - 1)) begin
        state_d = EMIT;
        for (int k = 0; k < PE_NUM; k++)
          pbuf_d[k] = prob(bus.i_state_dout[(PE_NUM-1-k)*2*DATA_WIDTH +: 2*DATA_WIDTH]);
      end else cnt_d = cnt_q + 1'b1;
      EMIT: if (bus.i_prob_ready) begin
        lane_d = lane_q + 1'b1;
        if (lane_q == '1) begin
          state_d = at_last ? DONE : READ;
          addr_d = at_last ? addr_q : addr_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      last_addr_q <= '0;
      lane_q <= '0;
      cnt_q <= '0;
      pbuf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      last_addr_q <= last_addr_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
      pbuf_q <= pbuf_d;
    end
  end
  assign bus.o_state_ena = {PE_NUM{state_q == READ}};
  assign bus.o_state_wea = '0;
  assign bus.o_state_addra = addr_q;
  assign bus.o_prob_valid = state_q == EMIT;
  assign bus.o_prob_data = pbuf_q[lane_q];
  assign bus.o_prob_index = {addr_q, lane_q};
  assign bus.o_prob_last = state_q == EMIT && at_last && lane_q == '1;
  assign o_busy = state_q != IDLE;
  assign o_done = state_q == DONE;
`ifdef QEA_READER_NORM_EN
  localparam logic [SW-1:0] ONE = SW'(1) << NUM_FRAC_BIT;
  logic [SW-1:0] sum_q, sum_d;
  logic err_q, err_d;
  // err is settled on the final handshake so it is already valid during DONE
  always_comb begin
    sum_d = start ? '0 : hs ? sum_q + SW'(bus.o_prob_data) : sum_q;
    err_d = start ? 1'b0 : hs && bus.o_prob_last ? (sum_d > ONE + SW'(NORM_TOL)) || (sum_d < ONE - SW'(NORM_TOL)) : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  assign o_norm_sum = sum_q;
  assign o_norm_err = err_q;
`else
  assign o_norm_sum = '0;
  assign o_norm_err = 1'b0;
`endif
endmodule

// File: tb/tb_qea_state_reader.sv
// tb_qea_state_reader: directed + randomized sweeps checked against an index-by-index |a|^2 reference.
module tb_qea_state_reader;
  localparam int RDL = 1;
  localparam longint unsigned ONE = 64'd1 << 30;
  logic clk = 0, rst = 1, i_start = 0;
  logic [5:0] i_qbit_num = '0;
  logic busy, done, norm_err;
  logic [49:0] norm_sum;
  logic [255:0] mem [256];
  int n_cmp = 0, n_err = 0;
  qea_state_reader_if bus ();
  qea_state_reader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num), .bus(bus),
    .o_busy(busy), .o_done(done), .o_norm_sum(norm_sum), .o_norm_err(norm_err)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) if (bus.o_state_ena[0]) bus.i_state_dout <= mem[bus.o_state_addra[7:0]];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [31:0] exp_prob(input int idx);
    logic [255:0] w = mem[idx / 4];
    logic [63:0] s = w[(3 - idx % 4) * 64 +: 64];
    longint re = longint'($signed(s[63:32]));
    longint im = longint'($signed(s[31:0]));
    longint unsigned p = (longint'(re * re) + longint'(im * im));
    p = p >> 30;
    return p > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : p[31:0];
  endfunction
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask
  task automatic rand_mem(input int words);
    for (int i = 0; i < words; i++)
      for (int j = 0; j < 8; j++) mem[i][j*32 +: 32] = $urandom >> $urandom_range(0, 12);
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, bus.o_prob_valid, 0);
    chk({tag, "_ena"}, bus.o_state_ena, 0);
    chk({tag, "_addra"}, bus.o_state_addra, 0);
    chk({tag, "_data"}, bus.o_prob_data, 0);
    chk({tag, "_index"}, bus.o_prob_index, 0);
    chk({tag, "_last"}, bus.o_prob_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_nsum"}, norm_sum, 0);
    chk({tag, "_nerr"}, norm_err, 0);
  endtask
  task automatic sweep(input int n, input int low_pct, input int abort_after, input bit poke);
    int ne, nb, beat, cyc, first;
    bit stalled, saw_done;
    logic [31:0] pd;
    logic [17:0] pidx;
    logic pl;
    longint unsigned sum;
    ne = n < 2 ? 2 : (n > 18 ? 18 : n);
    nb = 4 * (1 << (ne - 2));
    beat = 0; cyc = 0; first = -1; stalled = 0; saw_done = 0; sum = 0; pd = 0; pidx = 0; pl = 0;
    @(negedge clk);
    i_qbit_num = 6'(n);
    i_start = 1;
    bus.i_prob_ready = $urandom_range(0, 99) >= low_pct;
    @(negedge clk);
    i_start = 0;
    cyc = 1;
    chk("read_ena", bus.o_state_ena, 4'hF);
    chk("read_wea", bus.o_state_wea, 0);
    chk("read_addr0", bus.o_state_addra, 0);
    chk("read_novalid", bus.o_prob_valid, 0);
    chk("read_busy", busy, 1);
    while (beat < nb && cyc < 20000 && beat != abort_after) begin
      i_start = 0;
      bus.i_prob_ready = $urandom_range(0, 99) >= low_pct;
      if (done) saw_done = 1;
      if (stalled) begin
        chk("hold_valid", bus.o_prob_valid, 1);
        chk("hold_data", bus.o_prob_data, pd);
        chk("hold_index", bus.o_prob_index, pidx);
        chk("hold_last", bus.o_prob_last, pl);
      end
      if (bus.o_prob_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_valid_cycle", cyc, 2 + RDL);
        end
        if (poke && beat == 1) begin
          i_start = 1;
          i_qbit_num = 6'd10;
        end
        if (bus.i_prob_ready) begin
          chk("beat_data", bus.o_prob_data, exp_prob(beat));
          chk("beat_index", bus.o_prob_index, beat);
          chk("beat_last", bus.o_prob_last, beat == nb - 1);
          sum += exp_prob(beat);
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = bus.o_prob_data;
          pidx = bus.o_prob_index;
          pl = bus.o_prob_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 0;
    chk("no_timeout", beat >= nb || beat == abort_after, 1);
    chk("no_early_done", saw_done, 0);
    if (beat == abort_after) begin
      rst = 1;
      @(negedge clk);
      check_idle_zero("abort");
      rst = 0;
      saw_done = 0;
      repeat (4) begin
        @(negedge clk);
        if (done || busy) saw_done = 1;
      end
      chk("abort_stays_idle", saw_done, 0);
    end else begin
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
`ifdef QEA_READER_NORM_EN
      chk("norm_sum", norm_sum, sum);
      chk("norm_err", norm_err, sum > ONE + 256 || sum < ONE - 256);
`endif
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_fall", busy, 0);
      repeat (4) @(negedge clk);
      chk("idle_after_valid", bus.o_prob_valid, 0);
      chk("idle_after_busy", busy, 0);
`ifdef QEA_READER_NORM_EN
      chk("norm_sum_hold", norm_sum, sum);
`endif
    end
  endtask
  initial begin
    clear_mem();
    bus.i_prob_ready = 0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    i_start = 1;
    i_qbit_num = 6'd4;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);
    rst = 0;
    i_start = 0;
    @(negedge clk);
    chk("rst_beats_start_after", busy, 0);
    mem[0] = {64'h40000000_00000000, 192'h0};
    sweep(10, 0, -1, 0);
    clear_mem();
    mem[0] = {4{64'h20000000_00000000}};
    sweep(2, 0, -1, 0);
    clear_mem();
    mem[0] = {64'h80000000_80000000, 192'h0};
    sweep(2, 0, -1, 0);
    rand_mem(16);
    sweep(6, 30, -1, 0);
    rand_mem(256);
    sweep(10, 20, 100, 0);
    sweep(10, 10, -1, 0);
    rand_mem(4);
    sweep(1, 25, -1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
